// File: rtl/d5m_pattern_source.sv
// D5M sensor emulator: drives FVAL/LVAL/12-bit Bayer pixels, one per clock, with
// selectable deterministic test images and start/stop/single-frame control.
// Ports:
//   i_clk, i_rst          pixel clock, asynchronous active-high reset
//   i_start, i_stop       pulses: begin streaming / finish current frame then idle
//   i_single              level, sampled at frame start: stream one frame only
//   i_pattern, i_level    pattern select and solid value, sampled at frame start
//   o_fval, o_lval, o_d   frame valid, line valid, Bayer pixel (0 outside LVAL)
//   o_sof, o_eof          first / last FVAL-high cycle of a frame
//   o_busy                high in every state except IDLE
//   o_frame_cnt           completed frames, updates the cycle after o_eof
module d5m_pattern_source #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned H_BLANK  = 16,
    parameter int unsigned FV_LEAD  = 2,
    parameter int unsigned FV_TRAIL = 2,
    parameter int unsigned V_BLANK  = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_single,
    input  logic [1:0]  i_pattern,
    input  logic [11:0] i_level,
    output logic        o_fval,
    output logic        o_lval,
    output logic [11:0] o_d,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_busy,
    output logic [15:0] o_frame_cnt
);

    localparam int unsigned MAX_AB   = (H_ACTIVE > H_BLANK) ? H_ACTIVE : H_BLANK;
    localparam int unsigned MAX_CD   = (FV_LEAD > FV_TRAIL) ? FV_LEAD : FV_TRAIL;
    localparam int unsigned MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned MAX_LEN  = (MAX_ABCD > V_BLANK) ? MAX_ABCD : V_BLANK;
    localparam int unsigned CNT_W    = $clog2(MAX_LEN);
    localparam int unsigned Y_W      = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam int unsigned BAR_LEN  = H_ACTIVE / 8;
    localparam int unsigned BPOS_W   = (BAR_LEN > 1) ? $clog2(BAR_LEN) : 1;
    localparam int unsigned D_W      = 12;
    localparam int unsigned FC_W     = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_LINE,
        S_HBLK,
        S_TRAIL,
        S_VBLK
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;      // cycle index within the current state; x in LINE
    logic [Y_W-1:0]    y, y_nxt;
    logic [BPOS_W-1:0] bpos, bpos_nxt;    // pixel index within the current colour bar
    logic [2:0]        bar, bar_nxt;
    logic              stop_req, stop_nxt;
    logic [1:0]        pat, pat_nxt;
    logic [D_W-1:0]    level, level_nxt;
    logic [FC_W-1:0]   fcnt_nxt;

    logic              fval_nxt, lval_nxt, sof_nxt, eof_nxt, busy_nxt;
    logic [D_W-1:0]    d_nxt;
    logic              ch_en;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, counters and next-cycle output values
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        y_nxt     = y;
        bpos_nxt  = '0;
        bar_nxt   = '0;
        stop_nxt  = stop_req;
        pat_nxt   = pat;
        level_nxt = level;
        fcnt_nxt  = o_frame_cnt;
        ch_en     = 1'b0;
        d_nxt     = '0;

        if (state != S_IDLE && i_stop) begin
            stop_nxt = 1'b1;
        end

        unique case (state)
            S_IDLE: begin
                stop_nxt = 1'b0;
                // Stop beats start when both arrive together
                if (i_start && !i_stop) begin
                    state_nxt = S_LEAD;
                    cnt_nxt   = '0;
                    y_nxt     = '0;
                    pat_nxt   = i_pattern;
                    level_nxt = i_level;
                    stop_nxt  = i_single;
                end
            end
            S_LEAD: begin
                if (cnt == CNT_W'(FV_LEAD - 1)) begin
                    state_nxt = S_LINE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_LINE: begin
                if (cnt == CNT_W'(H_ACTIVE - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = (y == Y_W'(V_ACTIVE - 1)) ? S_TRAIL : S_HBLK;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                    // Bar index tracked by a wrap counter instead of dividing x
                    if (bpos == BPOS_W'(BAR_LEN - 1)) begin
                        bpos_nxt = '0;
                        bar_nxt  = bar + 3'd1;
                    end else begin
                        bpos_nxt = bpos + BPOS_W'(1);
                        bar_nxt  = bar;
                    end
                end
            end
            S_HBLK: begin
                if (cnt == CNT_W'(H_BLANK - 1)) begin
                    state_nxt = S_LINE;
                    cnt_nxt   = '0;
                    y_nxt     = y + Y_W'(1);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_TRAIL: begin
                if (cnt == CNT_W'(FV_TRAIL - 1)) begin
                    state_nxt = S_VBLK;
                    cnt_nxt   = '0;
                    fcnt_nxt  = o_frame_cnt + FC_W'(1);
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_VBLK: begin
                if (cnt == CNT_W'(V_BLANK - 1)) begin
                    cnt_nxt = '0;
                    if (stop_req || i_stop) begin
                        state_nxt = S_IDLE;
                        stop_nxt  = 1'b0;
                    end else begin
                        state_nxt = S_LEAD;
                        y_nxt     = '0;
                        pat_nxt   = i_pattern;
                        level_nxt = i_level;
                        stop_nxt  = i_single;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        fval_nxt = (state_nxt == S_LEAD) || (state_nxt == S_LINE) ||
                   (state_nxt == S_HBLK) || (state_nxt == S_TRAIL);
        lval_nxt = (state_nxt == S_LINE);
        sof_nxt  = (state_nxt == S_LEAD) && (state != S_LEAD);
        eof_nxt  = (state_nxt == S_TRAIL) && (cnt_nxt == CNT_W'(FV_TRAIL - 1));
        busy_nxt = (state_nxt != S_IDLE);

        // Bayer channel by (y[0], x[0]): 00=G 01=R 10=B 11=G; bar bits are {R,G,B}
        unique case ({y_nxt[0], cnt_nxt[0]})
            2'b00, 2'b11: ch_en = bar_nxt[1];
            2'b01:        ch_en = bar_nxt[2];
            default:      ch_en = bar_nxt[0];
        endcase

        if (lval_nxt) begin
            unique case (pat)
                2'd0:    d_nxt = level;
                2'd1:    d_nxt = D_W'({cnt_nxt, 2'b00});
                2'd2:    d_nxt = ch_en ? 12'hFFF : 12'h000;
                default: d_nxt = {o_frame_cnt[3:0], 4'(y_nxt), 4'(cnt_nxt)};
            endcase
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt         <= '0;
            y           <= '0;
            bpos        <= '0;
            bar         <= '0;
            stop_req    <= 1'b0;
            pat         <= '0;
            level       <= '0;
            o_frame_cnt <= '0;
            o_fval      <= 1'b0;
            o_lval      <= 1'b0;
            o_d         <= '0;
            o_sof       <= 1'b0;
            o_eof       <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            y           <= y_nxt;
            bpos        <= bpos_nxt;
            bar         <= bar_nxt;
            stop_req    <= stop_nxt;
            pat         <= pat_nxt;
            level       <= level_nxt;
            o_frame_cnt <= fcnt_nxt;
            o_fval      <= fval_nxt;
            o_lval      <= lval_nxt;
            o_d         <= d_nxt;
            o_sof       <= sof_nxt;
            o_eof       <= eof_nxt;
            o_busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_d5m_pattern_source.sv
// Scoreboard bench for d5m_pattern_source: stimulus pushes expected pixels and
// frame counts, a monitor pops and compares them as the DUT presents them.
module tb_d5m_pattern_source;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic        i_single = 1'b0;
    logic [1:0]  i_pattern = 2'd0;
    logic [11:0] i_level = 12'd0;
    logic        o_fval, o_lval, o_sof, o_eof, o_busy;
    logic [11:0] o_d;
    logic [15:0] o_frame_cnt;

    int checks = 0;
    int errors = 0;

    logic [11:0] pix_q[$];
    logic [15:0] fcnt_q[$];
    logic [11:0] cap [16][4][16];

    int   m_fv_cnt = 0;
    int   m_gap = 0;
    int   m_line = 0;
    int   m_px = 0;
    logic m_prev_lval = 1'b0;
    logic m_pend_fc = 1'b0;
    logic [11:0] m_exp_px;
    logic [15:0] m_exp_fc;

    d5m_pattern_source #(
        .H_ACTIVE(16), .V_ACTIVE(4), .H_BLANK(4),
        .FV_LEAD(2), .FV_TRAIL(2), .V_BLANK(6)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_stop(i_stop),
        .i_single(i_single), .i_pattern(i_pattern), .i_level(i_level),
        .o_fval(o_fval), .o_lval(o_lval), .o_d(o_d), .o_sof(o_sof),
        .o_eof(o_eof), .o_busy(o_busy), .o_frame_cnt(o_frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [11:0] model_pix(input logic [1:0] pat, input logic [11:0] lvl,
                                              input logic [15:0] fc, input int x, input int y);
        logic [2:0] b;
        logic [3:0] xs, ys;
        logic       en;
        b  = 3'(x / 2);
        xs = 4'(x);
        ys = 4'(y);
        if (!ys[0] && !xs[0])  en = b[1];
        else if (!ys[0])       en = b[2];
        else if (!xs[0])       en = b[0];
        else                   en = b[1];
        case (pat)
            2'd0:    return lvl;
            2'd1:    return 12'(x * 4);
            2'd2:    return en ? 12'hFFF : 12'h000;
            default: return {fc[3:0], ys, xs};
        endcase
    endfunction

    task automatic push_frame(input logic [1:0] pat, input logic [11:0] lvl, input logic [15:0] fc);
        for (int yy = 0; yy < 4; yy++)
            for (int xx = 0; xx < 16; xx++)
                pix_q.push_back(model_pix(pat, lvl, fc, xx, yy));
        fcnt_q.push_back(fc + 16'd1);
    endtask

    task automatic wait_eof();
        int n = 0;
        do begin tick(); n++; end while (!o_eof && n < 300);
        checks++;
        if (!o_eof) begin
            errors++;
            $display("FAIL eof_timeout: %0d cycles without o_eof, required fewer than 300", n);
        end
    endtask

    task automatic to_next(input logic [1:0] pat, input logic [11:0] lvl, input logic [15:0] fc);
        int n = 0;
        wait_eof();
        i_pattern = pat;
        i_level   = lvl;
        push_frame(pat, lvl, fc);
        do begin tick(); n++; end while (!o_sof && n < 20);
        chk("eof_to_sof_cycles", 32'(n), 32'd7);
    endtask

    task automatic wait_idle_after_eof();
        int n = 0;
        do begin tick(); n++; end while (o_busy && n < 20);
        chk("busy_fall_cycles", 32'(n), 32'd7);
        chk("idle_fval", 32'(o_fval), 32'd0);
    endtask

    // Monitor: consumes expected pixels on LVAL and frame counts after o_eof
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_fv_cnt = 0; m_gap = 0; m_line = 0; m_px = 0;
                m_prev_lval = 1'b0; m_pend_fc = 1'b0;
            end else begin
                if (m_pend_fc) begin
                    m_pend_fc = 1'b0;
                    if (fcnt_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL frame_cnt_unexpected: got 0x%0h with no expected entry", o_frame_cnt);
                    end else begin
                        m_exp_fc = fcnt_q.pop_front();
                        chk("frame_cnt", 32'(o_frame_cnt), 32'(m_exp_fc));
                    end
                end
                if (o_sof) begin
                    chk("sof_fval", 32'(o_fval), 32'd1);
                    m_fv_cnt = 0; m_line = 0; m_px = 0;
                end
                if (o_fval) m_fv_cnt++;
                if (m_prev_lval && !o_lval) begin
                    chk("line_len", 32'(m_px), 32'd16);
                    m_line++; m_px = 0; m_gap = 0;
                end
                if (!m_prev_lval && o_lval && m_line > 0)
                    chk("hblank_len", 32'(m_gap), 32'd4);
                if (!o_lval && o_fval) m_gap++;
                if (o_lval) begin
                    if (pix_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL pixel_unexpected: got 0x%0h with empty expected queue", o_d);
                    end else begin
                        m_exp_px = pix_q.pop_front();
                        chk("pixel", 32'(o_d), 32'(m_exp_px));
                    end
                    if (m_line < 4 && m_px < 16) cap[o_frame_cnt[3:0]][m_line][m_px] = o_d;
                    m_px++;
                end else begin
                    chk("d_blank", 32'(o_d), 32'd0);
                end
                if (o_eof) begin
                    chk("fval_len", 32'(m_fv_cnt), 32'd80);
                    chk("lines_per_frame", 32'(m_line), 32'd4);
                    m_pend_fc = 1'b1;
                end
                m_prev_lval = o_lval;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        repeat (3) tick();
        chk("rst_fval", 32'(o_fval), 32'd0);
        chk("rst_lval", 32'(o_lval), 32'd0);
        chk("rst_d", 32'(o_d), 32'd0);
        chk("rst_sof_eof", 32'({o_sof, o_eof}), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
        rst = 1'b0;
        tick();

        // Frame 0: solid 0xABC, 1-cycle start latency
        i_pattern = 2'd0;
        i_level   = 12'hABC;
        push_frame(2'd0, 12'hABC, 16'd0);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("start_sof", 32'(o_sof), 32'd1);
        chk("start_fval", 32'(o_fval), 32'd1);
        chk("start_busy", 32'(o_busy), 32'd1);
        repeat (10) tick();
        i_level   = 12'h555;
        i_pattern = 2'd1;

        // Continuous ramp frames
        to_next(2'd1, 12'h555, 16'd1);
        chk("solid_y0_x0", 32'(cap[0][0][0]), 32'hABC);
        chk("solid_y3_x15", 32'(cap[0][3][15]), 32'hABC);
        to_next(2'd1, 12'h555, 16'd2);
        chk("ramp_x1", 32'(cap[1][0][1]), 32'h004);
        chk("ramp_x15", 32'(cap[1][2][15]), 32'h03C);
        to_next(2'd1, 12'h555, 16'd3);
        to_next(2'd2, 12'h555, 16'd4);
        to_next(2'd3, 12'h555, 16'd5);
        chk("bars_y0_x14", 32'(cap[4][0][14]), 32'hFFF);
        chk("bars_y0_x15", 32'(cap[4][0][15]), 32'hFFF);
        chk("bars_y0_x2", 32'(cap[4][0][2]), 32'h000);
        chk("bars_y0_x3", 32'(cap[4][0][3]), 32'h000);
        chk("bars_y0_x4", 32'(cap[4][0][4]), 32'hFFF);
        chk("bars_y1_x0", 32'(cap[4][1][0]), 32'h000);
        chk("bars_y1_x2", 32'(cap[4][1][2]), 32'hFFF);

        // Mid-frame pattern/level change must wait for the next frame
        repeat (10) tick();
        i_pattern = 2'd0;
        i_level   = 12'h123;
        to_next(2'd0, 12'h123, 16'd6);
        chk("stamp_y2_x9", 32'(cap[5][2][9]), 32'h529);
        chk("stamp_y3_x15", 32'(cap[5][3][15]), 32'h53F);

        // Stop mid-frame: frame completes, then idle
        repeat (20) tick();
        i_stop = 1'b1;
        tick();
        i_stop = 1'b0;
        wait_eof();
        wait_idle_after_eof();
        chk("solid2_y1_x7", 32'(cap[6][1][7]), 32'h123);
        chk("frame_cnt_after_stop", 32'(o_frame_cnt), 32'd7);

        // Single frame
        i_single  = 1'b1;
        i_pattern = 2'd1;
        push_frame(2'd1, 12'h000, 16'd7);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        chk("single_sof", 32'(o_sof), 32'd1);
        repeat (30) tick();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        wait_eof();
        wait_idle_after_eof();
        i_single = 1'b0;
        repeat (3) tick();
        chk("single_busy_stays_low", 32'(o_busy), 32'd0);
        chk("pix_q_drained", 32'(pix_q.size()), 32'd0);
        chk("fcnt_q_drained", 32'(fcnt_q.size()), 32'd0);

        // Start and stop together in IDLE
        i_start = 1'b1;
        i_stop  = 1'b1;
        tick();
        i_start = 1'b0;
        i_stop  = 1'b0;
        chk("startstop_busy", 32'(o_busy), 32'd0);
        chk("startstop_fval", 32'(o_fval), 32'd0);
        tick();
        chk("startstop_busy2", 32'(o_busy), 32'd0);

        // Asynchronous reset during LINE
        i_pattern = 2'd1;
        push_frame(2'd1, 12'h000, 16'd8);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n = 0;
        do begin tick(); n++; end while (!o_lval && n < 20);
        repeat (3) tick();
        chk("pre_reset_lval", 32'(o_lval), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_fval", 32'(o_fval), 32'd0);
        chk("async_rst_lval", 32'(o_lval), 32'd0);
        chk("async_rst_d", 32'(o_d), 32'd0);
        chk("async_rst_frame_cnt", 32'(o_frame_cnt), 32'd0);
        chk("async_rst_busy", 32'(o_busy), 32'd0);
        pix_q.delete();
        fcnt_q.delete();
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        chk("post_reset_idle", 32'({o_busy, o_fval, o_eof}), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
